// File: rtl/oam_dma_ctrl_pkg.sv
// Shared constants and state encoding for the sprite-DMA controller.
package oam_dma_ctrl_pkg;
    localparam logic [15:0] OAM_DMA_REG_ADDR = 16'h4014;
    localparam logic [15:0] OAMDATA_ADDR     = 16'h2004;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } dma_state_e;
endpackage

// File: rtl/oam_dma_ctrl_if.sv
// CPU / bus signals shared between the CPU side (master) and the DMA controller (slave).
interface oam_dma_ctrl_if;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_we;
    logic [7:0]  bus_rdata;
    logic        cpu_rdy;
    logic        dma_active;
    logic        bus_sel;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wdata;
    logic        dma_we;

    modport master (
        output cpu_addr, cpu_wdata, cpu_we, bus_rdata,
        input  cpu_rdy, dma_active, bus_sel, dma_addr, dma_wdata, dma_we
    );

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_we, bus_rdata,
        output cpu_rdy, dma_active, bus_sel, dma_addr, dma_wdata, dma_we
    );
endinterface

// File: rtl/oam_dma_ctrl.sv
// OAM sprite-DMA controller: a write to $4014 stalls the CPU and copies page $XX00-$XXFF to $2004.
// Define OAM_DMA_ALIGN_EN to insert an ALIGN cycle so every READ lands on parity=0.
module oam_dma_ctrl
    import oam_dma_ctrl_pkg::*;
(
    input  logic           clk,
    input  logic           reset_l,
    oam_dma_ctrl_if.slave  bus
);

    dma_state_e  state, state_nxt;
    logic [7:0]  page;
    logic [7:0]  idx;
    logic [7:0]  rd_buf;
    logic        trigger;

    // Strobes while a transfer is running are spurious (CPU is held), so only IDLE listens.
    assign trigger = (state == IDLE) && bus.cpu_we && (bus.cpu_addr == OAM_DMA_REG_ADDR);

`ifdef OAM_DMA_ALIGN_EN
    logic parity;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) parity <= 1'b0;
        else          parity <= ~parity;
    end
`endif

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state  <= IDLE;
            page   <= 8'h00;
            idx    <= 8'h00;
            rd_buf <= 8'h00;
        end else begin
            state <= state_nxt;
            if (trigger) begin
                page <= bus.cpu_wdata;
                idx  <= 8'h00;
            end
            if (state == READ)
                rd_buf <= bus.bus_rdata;
            if (state == WRITE && idx != 8'hFF)
                idx <= idx + 8'h01;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (trigger) state_nxt = HALT;
`ifdef OAM_DMA_ALIGN_EN
            HALT:  state_nxt = parity ? READ : ALIGN;
`else
            HALT:  state_nxt = READ;
`endif
            ALIGN: state_nxt = READ;
            READ:  state_nxt = WRITE;
            WRITE: state_nxt = (idx == 8'hFF) ? IDLE : READ;
            default: state_nxt = IDLE;
        endcase
    end

    logic        active;
    logic [15:0] addr_q;
    logic [7:0]  wdata_q;

    always_comb begin
        active  = (state != IDLE);
        addr_q  = 16'h0000;
        wdata_q = 8'h00;
        if (state == READ) begin
            addr_q = {page, idx};
        end else if (state == WRITE) begin
            addr_q  = OAMDATA_ADDR;
            wdata_q = rd_buf;
        end
    end

    assign bus.dma_active = active;
    assign bus.cpu_rdy    = ~active;
    assign bus.bus_sel    = (state == READ) || (state == WRITE);
    assign bus.dma_we     = (state == WRITE);
    assign bus.dma_addr   = addr_q;
    assign bus.dma_wdata  = wdata_q;

endmodule
